reg_file: RTL and testbench
===========================

# reg_file

General-purpose register file of the basic processor datapath: 32 registers of 32 bits, two combinational read ports (A, B) and one synchronous write port (D). Sits between decode, which supplies register addresses, and the ALU/writeback stage, which consumes the operands and returns results. Register r0 is hardwired to zero.

## Interface
Parameters (shared constants):
- ADDR_WIDTH, 5: register address width.
- REG_FILE_WIDTH, 32: data width of each register.
- REG_FILE_NREG, 32: number of registers, always equal to 2^ADDR_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- wrt_en  input  1  write enable for port D.
- addrA  input  ADDR_WIDTH  read address, port A.
- addrB  input  ADDR_WIDTH  read address, port B.
- addrD  input  ADDR_WIDTH  write address, port D.
- d  input  REG_FILE_WIDTH  write data.
- data_a  output  REG_FILE_WIDTH  contents of register addrA.
- data_b  output  REG_FILE_WIDTH  contents of register addrB.

## Operation
- Storage: registers r1..r31. r0 has no storage and always reads 0.
- Write: on a rising clk edge with rst=0, wrt_en=1 and addrD≠0, load d into r[addrD]. Otherwise no register changes.
- Write to r0: silently ignored, whatever the value of wrt_en.
- Read: data_a = (addrA==0) ? 0 : r[addrA]; data_b follows the same rule with addrB. Both reads are purely combinational and independent.
- Both read ports may use the same address, including addrD. Reads and writes have no port conflicts.
- X or Z on any address must not corrupt stored state. The write is qualified by wrt_en, so a disabled write with an undefined addrD leaves every register unchanged.

## Timing
- Reset: on a rising edge with rst=1, r1..r31 clear to 0. Reset takes priority over a simultaneous write. One cycle later data_a and data_b read 0 for every address.
- Before the first reset, register contents are undefined. Only r0 is guaranteed to read 0.
- Read latency: 0 cycles. An output changes within the same cycle as its address changes, or right after the edge that updates the addressed register.
- Write latency: 1 edge. A value written at edge N is visible on the read ports after edge N.
- Same-cycle read of a register that is being written: the read returns the old value until the edge, unless REG_FILE_BYPASS_EN is defined.
- rst asserted mid-sequence clears state at that edge and discards any pending write.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: if wrt_en=1, addrD≠0 and addrX==addrD, then data_X = d combinationally (write-through forwarding on both ports). A forwarded r0 still reads 0.
- Not defined: reads always return the stored register value, with no forwarding.

## Structure
- Shared package/header: ADDR_WIDTH, REG_FILE_WIDTH and REG_FILE_NREG. The processor shares these with decode and the ALU.
- One sub-module: reg_file_read_port. It holds the address decode, the r0-zero forcing and the optional bypass mux, and is instantiated twice (ports A and B).

## Test plan
- Reset, then read all addresses: assert rst for one edge, sweep addrA/addrB over 0..31 -> data_a=data_b=0 everywhere.
- Write disabled: wrt_en=0, addrD=6, d=0x0000_4544, one edge -> r6 still reads 0 on both ports.
- Write and read back: wrt_en=1, addrD=5, d=0xDEAD_BEEF, one edge, then addrA=5 and addrB=5 -> both ports read 0xDEAD_BEEF. A second write of 0x1234_5678 to r31 leaves r5 unchanged.
- r0 hardwired: wrt_en=1, addrD=0, d=0x0000_4541, several edges, addrA=0, addrB=0 -> data_a=data_b=0.
- Same-cycle read/write: r7=0x11, then wrt_en=1, addrD=7, d=0x22, addrA=7 before the edge -> data_a=0x11 without the macro, 0x22 with REG_FILE_BYPASS_EN. After the edge, 0x22 in both builds.
- Reset priority: r3=0xAA, then rst=1 together with wrt_en=1, addrD=3, d=0xBB, one edge -> r3 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types; also used by decode and the ALU.
package reg_file_pkg;

  localparam int unsigned ADDR_WIDTH     = 5;
  localparam int unsigned REG_FILE_WIDTH = 32;
  localparam int unsigned REG_FILE_NREG  = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef logic [REG_FILE_WIDTH-1:0] data_t;
  typedef data_t [REG_FILE_NREG-1:0] reg_array_t;

  // Write-port request as seen by storage and by the forwarding path
  typedef struct packed {
    logic  en;
    addr_t addr;
    data_t data;
  } wr_req_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: two read ports (A, B) and one write port (D).
interface reg_file_if;
  import reg_file_pkg::*;

  logic  wrt_en;
  addr_t addrA;
  addr_t addrB;
  addr_t addrD;
  data_t d;
  data_t data_a;
  data_t data_b;

  // Decode/writeback side
  modport master (
    output wrt_en, addrA, addrB, addrD, d,
    input  data_a, data_b
  );

  // Register file side
  modport slave (
    input  wrt_en, addrA, addrB, addrD, d,
    output data_a, data_b
  );
endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: address select, r0 forced to zero and,
// when REG_FILE_BYPASS_EN is defined, write-through forwarding from port D.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  reg_array_t regs,
`ifdef REG_FILE_BYPASS_EN
  input  wr_req_t    wr,
`endif
  input  addr_t      addr,
  output data_t      data
);

  // Select the addressed register; r0 has no storage and reads zero
  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = regs[addr];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr.en && (wr.addr != '0) && (wr.addr == addr)) begin
      data = wr.data;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file, r0 hardwired to zero.
// Optional write-through forwarding to both read ports: REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  reg_array_t regs;
  wr_req_t    wr;

  assign wr = '{en: bus.wrt_en, addr: bus.addrD, data: bus.d};

  // Storage update: reset wins over a write; writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wr.en && (wr.addr != '0)) begin
      regs[wr.addr] <= wr.data;
    end
  end

  reg_file_read_port u_port_a (
    .regs (regs),
`ifdef REG_FILE_BYPASS_EN
    .wr   (wr),
`endif
    .addr (bus.addrA),
    .data (bus.data_a)
  );

  reg_file_read_port u_port_b (
    .regs (regs),
`ifdef REG_FILE_BYPASS_EN
    .wr   (wr),
`endif
    .addr (bus.addrB),
    .data (bus.data_b)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (both bypass builds).
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_if bus ();

  reg_file u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input addr_t a, input data_t v);
    bus.wrt_en = 1'b1;
    bus.addrD  = a;
    bus.d      = v;
    tick();
    bus.wrt_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.addrA = '0;
    bus.addrB = '0;
    #1;
    checks++;
    if (bus.data_a !== 32'h0) begin
      errors++;
      $display("FAIL r0_before_reset got %h want %h", bus.data_a, 32'h0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.addrA = addr_t'(i);
      bus.addrB = addr_t'(31 - i);
      #1;
      checks++;
      if (bus.data_a !== 32'h0) begin
        errors++;
        $display("FAIL reset_sweep_a[%0d] got %h want %h", i, bus.data_a, 32'h0);
      end
      checks++;
      if (bus.data_b !== 32'h0) begin
        errors++;
        $display("FAIL reset_sweep_b[%0d] got %h want %h", 31 - i, bus.data_b, 32'h0);
      end
    end
  endtask

  task automatic test_write_disabled();
    bus.wrt_en = 1'b0;
    bus.addrD  = 5'd6;
    bus.d      = 32'h0000_4544;
    tick();
    bus.addrA = 5'd6;
    bus.addrB = 5'd6;
    #1;
    checks++;
    if (bus.data_a !== 32'h0) begin
      errors++;
      $display("FAIL wr_disabled_a got %h want %h", bus.data_a, 32'h0);
    end
    checks++;
    if (bus.data_b !== 32'h0) begin
      errors++;
      $display("FAIL wr_disabled_b got %h want %h", bus.data_b, 32'h0);
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEAD_BEEF);
    bus.addrA = 5'd5;
    bus.addrB = 5'd5;
    #1;
    checks++;
    if (bus.data_a !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_r5_a got %h want %h", bus.data_a, 32'hDEAD_BEEF);
    end
    checks++;
    if (bus.data_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_r5_b got %h want %h", bus.data_b, 32'hDEAD_BEEF);
    end
    write_reg(5'd31, 32'h1234_5678);
    bus.addrA = 5'd5;
    bus.addrB = 5'd31;
    #1;
    checks++;
    if (bus.data_a !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL r5_kept got %h want %h", bus.data_a, 32'hDEAD_BEEF);
    end
    checks++;
    if (bus.data_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_r31_b got %h want %h", bus.data_b, 32'h1234_5678);
    end
    write_reg(5'd1, 32'hA5A5_0001);
    bus.addrA = 5'd1;
    bus.addrB = 5'd6;
    #1;
    checks++;
    if (bus.data_a !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL rd_r1_a got %h want %h", bus.data_a, 32'hA5A5_0001);
    end
    checks++;
    if (bus.data_b !== 32'h0) begin
      errors++;
      $display("FAIL r6_untouched got %h want %h", bus.data_b, 32'h0);
    end
  endtask

  task automatic test_r0();
    bus.wrt_en = 1'b1;
    bus.addrD  = 5'd0;
    bus.d      = 32'h0000_4541;
    for (int i = 0; i < 3; i++) tick();
    bus.wrt_en = 1'b0;
    bus.addrA  = 5'd0;
    bus.addrB  = 5'd0;
    #1;
    checks++;
    if (bus.data_a !== 32'h0) begin
      errors++;
      $display("FAIL r0_a got %h want %h", bus.data_a, 32'h0);
    end
    checks++;
    if (bus.data_b !== 32'h0) begin
      errors++;
      $display("FAIL r0_b got %h want %h", bus.data_b, 32'h0);
    end
  endtask

  task automatic test_same_cycle();
    data_t exp_pre;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    write_reg(5'd7, 32'h11);
    bus.wrt_en = 1'b1;
    bus.addrD  = 5'd7;
    bus.d      = 32'h22;
    bus.addrA  = 5'd7;
    bus.addrB  = 5'd7;
    #1;
    checks++;
    if (bus.data_a !== exp_pre) begin
      errors++;
      $display("FAIL same_cycle_a got %h want %h", bus.data_a, exp_pre);
    end
    checks++;
    if (bus.data_b !== exp_pre) begin
      errors++;
      $display("FAIL same_cycle_b got %h want %h", bus.data_b, exp_pre);
    end
    tick();
    bus.wrt_en = 1'b0;
    #1;
    checks++;
    if (bus.data_a !== 32'h22) begin
      errors++;
      $display("FAIL after_edge_a got %h want %h", bus.data_a, 32'h22);
    end
    // Forwarding must never make r0 nonzero
    bus.wrt_en = 1'b1;
    bus.addrD  = 5'd0;
    bus.d      = 32'hFFFF_FFFF;
    bus.addrA  = 5'd0;
    #1;
    checks++;
    if (bus.data_a !== 32'h0) begin
      errors++;
      $display("FAIL fwd_r0 got %h want %h", bus.data_a, 32'h0);
    end
    bus.wrt_en = 1'b0;
  endtask

  task automatic test_x_addr();
    bus.wrt_en = 1'b0;
    bus.addrD  = 'x;
    bus.d      = 32'hBAD0_BAD0;
    tick();
    bus.addrA = 5'd5;
    bus.addrB = 5'd31;
    #1;
    checks++;
    if (bus.data_a !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL x_addr_r5 got %h want %h", bus.data_a, 32'hDEAD_BEEF);
    end
    checks++;
    if (bus.data_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL x_addr_r31 got %h want %h", bus.data_b, 32'h1234_5678);
    end
  endtask

  task automatic test_reset_priority();
    write_reg(5'd3, 32'hAA);
    bus.addrA = 5'd3;
    #1;
    checks++;
    if (bus.data_a !== 32'hAA) begin
      errors++;
      $display("FAIL r3_pre got %h want %h", bus.data_a, 32'hAA);
    end
    rst        = 1'b1;
    bus.wrt_en = 1'b1;
    bus.addrD  = 5'd3;
    bus.d      = 32'hBB;
    tick();
    rst        = 1'b0;
    bus.wrt_en = 1'b0;
    bus.addrB  = 5'd5;
    #1;
    checks++;
    if (bus.data_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio_r3 got %h want %h", bus.data_a, 32'h0);
    end
    checks++;
    if (bus.data_b !== 32'h0) begin
      errors++;
      $display("FAIL rst_clears_r5 got %h want %h", bus.data_b, 32'h0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.wrt_en = 1'b0;
    bus.addrA  = '0;
    bus.addrB  = '0;
    bus.addrD  = '0;
    bus.d      = '0;
    #2;
    test_reset();
    test_write_disabled();
    test_write_read();
    test_r0();
    test_same_cycle();
    test_x_addr();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
